axi_riscv_resv_tracker: RTL and testbench

AXI_RISCV_RESV_TRACKER -- requirements
Module: axi_riscv_resv_tracker

---
 rtl/axi_riscv_resv_pkg.sv | 30 +++
 rtl/axi_riscv_resv_fifo.sv | 61 ++++++
 rtl/axi_riscv_resv_tracker.sv | 214 +++++++++++++++++++++
 tb/tb_axi_riscv_resv_tracker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_riscv_resv_pkg.sv
// Shared types for the LR/SC reservation tracker: table entry, SC verdict, tag width helper.
// Entries are stored at the maximum supported widths; narrower IDs and tags are zero-extended.
package axi_riscv_resv_pkg;

    localparam int unsigned RESV_MAX_ID_WIDTH  = 32;
    localparam int unsigned RESV_MAX_TAG_WIDTH = 64;

    typedef logic [RESV_MAX_ID_WIDTH-1:0]  resv_id_t;
    typedef logic [RESV_MAX_TAG_WIDTH-1:0] resv_tag_t;

    typedef struct packed {
        logic      valid;
        resv_id_t  id;
        resv_tag_t tag;
    } resv_entry_t;

    typedef struct packed {
        resv_id_t id;
        logic     success;
    } resv_verdict_t;

    // Number of address bits above the granule offset.
    function automatic int unsigned resv_tag_width(input int unsigned addr_width,
                                                   input int unsigned granule_bytes);
        int unsigned shift;
        shift = $clog2(granule_bytes);
        return (addr_width > shift) ? addr_width - shift : 1;
    endfunction

endpackage

// File: rtl/axi_riscv_resv_fifo.sv
// SC verdict FIFO: power-of-two depth, full/empty flags, first word visible on data_o.
// The output is forced to zero while empty so idle outputs are deterministic.
module axi_riscv_resv_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_reg == CNT_W'(DEPTH));
    assign empty_o = (count_reg == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign data_o = empty_o ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/axi_riscv_resv_tracker.sv
// LR/SC reservation table snooping the AR/AW channels and producing in-order SC verdicts.
// Define AXI_RISCV_RESV_TIMEOUT_EN to let reservations expire after TIMEOUT_CYCLES cycles.
module axi_riscv_resv_tracker
    import axi_riscv_resv_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH     = 0,
    parameter int unsigned AXI_ID_WIDTH       = 0,
    parameter int unsigned NUM_RESV           = 4,
    parameter int unsigned RESV_GRANULE_BYTES = 8,
    parameter int unsigned RESULT_DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             ar_valid_i,
    input  logic                             ar_ready_i,
    input  logic [AXI_ADDR_WIDTH-1:0]        ar_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]          ar_id_i,
    input  logic                             ar_lock_i,
    input  logic                             aw_valid_i,
    input  logic                             aw_ready_i,
    input  logic [AXI_ADDR_WIDTH-1:0]        aw_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]          aw_id_i,
    input  logic                             aw_lock_i,
    input  logic [5:0]                       aw_atop_i,
    output logic                             sc_stall_o,
    output logic                             sc_valid_o,
    input  logic                             sc_ready_i,
    output logic [AXI_ID_WIDTH-1:0]          sc_id_o,
    output logic                             sc_success_o,
    output logic [$clog2(NUM_RESV+1)-1:0]    resv_count_o
);

    localparam int unsigned GRAN_SHIFT = $clog2(RESV_GRANULE_BYTES);
    localparam int unsigned TAG_W      = resv_tag_width(AXI_ADDR_WIDTH, RESV_GRANULE_BYTES);
    localparam int unsigned IDX_W      = (NUM_RESV > 1) ? $clog2(NUM_RESV) : 1;
    localparam int unsigned CNT_W      = $clog2(NUM_RESV + 1);

    if (NUM_RESV < 1 || NUM_RESV > 16) begin : g_bad_num_resv
        $error("NUM_RESV must be in 1..16");
    end
    if (RESV_GRANULE_BYTES < 8 || (RESV_GRANULE_BYTES & (RESV_GRANULE_BYTES - 1)) != 0) begin : g_bad_granule
        $error("RESV_GRANULE_BYTES must be a power of two, at least 8");
    end
    if (RESULT_DEPTH < 2 || (RESULT_DEPTH & (RESULT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RESULT_DEPTH must be a power of two, at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    resv_entry_t      table_reg  [NUM_RESV];
    resv_entry_t      table_next [NUM_RESV];
    logic [IDX_W-1:0] victim_reg;
    logic [IDX_W-1:0] victim_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    logic             lr_ev;
    logic             aw_hs;
    logic             sc_ev;
    logic             wr_ev;
    logic             sc_success;
    resv_id_t         ar_id_ext;
    resv_id_t         aw_id_ext;
    resv_tag_t        ar_tag;
    resv_tag_t        aw_tag;

    logic [NUM_RESV-1:0] expired;
    logic [NUM_RESV-1:0] live;
    logic [NUM_RESV-1:0] aw_id_hit;
    logic [NUM_RESV-1:0] aw_tag_hit;
    logic [NUM_RESV-1:0] ar_id_hit;
    logic [NUM_RESV-1:0] clear;
    logic [IDX_W-1:0]    alloc_idx;

    resv_verdict_t    verdict_in;
    resv_verdict_t    verdict_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             unused_bits;

    assign lr_ev = ar_valid_i && ar_ready_i && ar_lock_i;
    assign aw_hs = aw_valid_i && aw_ready_i;
    assign sc_ev = aw_hs && aw_lock_i && (aw_atop_i == 6'd0);
    assign wr_ev = aw_hs && !sc_ev;

    assign ar_id_ext = resv_id_t'(ar_id_i);
    assign aw_id_ext = resv_id_t'(aw_id_i);
    assign ar_tag    = resv_tag_t'(ar_addr_i[GRAN_SHIFT +: TAG_W]);
    assign aw_tag    = resv_tag_t'(aw_addr_i[GRAN_SHIFT +: TAG_W]);

`ifdef AXI_RISCV_RESV_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] timer_reg [NUM_RESV];

    // Timers restart on (re)allocation and only run while the entry holds a reservation.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_RESV; i++) begin
            if (!rst_ni) begin
                timer_reg[i] <= '0;
            end else if (lr_ev && alloc_idx == IDX_W'(i)) begin
                timer_reg[i] <= '0;
            end else if (table_reg[i].valid) begin
                timer_reg[i] <= timer_reg[i] + TMR_W'(1);
            end
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_RESV; gi++) begin : g_entry
`ifdef AXI_RISCV_RESV_TIMEOUT_EN
        assign expired[gi] = table_reg[gi].valid && (timer_reg[gi] == TMR_W'(TIMEOUT_CYCLES - 1));
`else
        assign expired[gi] = 1'b0;
`endif
        // An entry expiring this cycle is already invisible to every match below.
        assign live[gi]       = table_reg[gi].valid && !expired[gi];
        assign aw_id_hit[gi]  = live[gi] && (table_reg[gi].id == aw_id_ext);
        assign aw_tag_hit[gi] = live[gi] && (table_reg[gi].tag == aw_tag);
        assign ar_id_hit[gi]  = live[gi] && (table_reg[gi].id == ar_id_ext);
        assign clear[gi]      = (sc_ev && (aw_id_hit[gi] || (sc_success && aw_tag_hit[gi])))
                              || (wr_ev && aw_tag_hit[gi]);
    end

    assign sc_success = sc_ev && |(aw_id_hit & aw_tag_hit);

    // LR placement: same-ID entry, else lowest free entry, else round-robin victim.
    always_comb begin
        logic found;
        found       = 1'b0;
        alloc_idx   = victim_reg;
        victim_next = victim_reg;
        for (int i = 0; i < NUM_RESV; i++) begin
            if (!found && ar_id_hit[i]) begin
                alloc_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
        for (int i = 0; i < NUM_RESV; i++) begin
            if (!found && !live[i]) begin
                alloc_idx = IDX_W'(i);
                found     = 1'b1;
            end
        end
        if (lr_ev && !found) begin
            victim_next = (victim_reg == IDX_W'(NUM_RESV - 1)) ? '0 : victim_reg + IDX_W'(1);
        end
    end

    // Clears from the AW side land first; the LR allocation then overrides its slot.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_RESV; i++) begin
            table_next[i]       = table_reg[i];
            table_next[i].valid = live[i] && !clear[i];
            if (lr_ev && alloc_idx == IDX_W'(i)) begin
                table_next[i] = '{valid: 1'b1, id: ar_id_ext, tag: ar_tag};
            end
            if (table_next[i].valid) begin
                count_next = count_next + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_RESV; i++) begin
                table_reg[i] <= '0;
            end
            victim_reg <= '0;
            count_reg  <= '0;
        end else begin
            for (int i = 0; i < NUM_RESV; i++) begin
                table_reg[i] <= table_next[i];
            end
            victim_reg <= victim_next;
            count_reg  <= count_next;
        end
    end

    assign verdict_in = '{id: aw_id_ext, success: sc_success};
    assign fifo_pop   = sc_valid_o && sc_ready_i;

    axi_riscv_resv_fifo #(
        .WIDTH ($bits(resv_verdict_t)),
        .DEPTH (RESULT_DEPTH)
    ) i_verdict_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (sc_ev),
        .data_i  (verdict_in),
        .pop_i   (fifo_pop),
        .data_o  (verdict_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign sc_stall_o   = fifo_full;
    assign sc_valid_o   = !fifo_empty;
    assign sc_id_o      = verdict_out.id[AXI_ID_WIDTH-1:0];
    assign sc_success_o = verdict_out.success;
    assign resv_count_o = count_reg;

    assign unused_bits = ^{verdict_out.id >> AXI_ID_WIDTH,
                           ar_addr_i[GRAN_SHIFT-1:0], aw_addr_i[GRAN_SHIFT-1:0]};

    // An SC arriving while the FIFO is full and not draining loses its verdict.
    sc_overflow_check: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(sc_ev && sc_stall_o && !fifo_pop));

endmodule

// File: tb/tb_axi_riscv_resv_tracker.sv
// Directed bench for axi_riscv_resv_tracker; expected SC verdicts are queued when the SC is driven.
// Define AXI_RISCV_RESV_TIMEOUT_EN to build the expiry variant and its expectation.
module tb_axi_riscv_resv_tracker;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned NR = 4;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          ar_valid, ar_ready, ar_lock;
    logic [AW-1:0] ar_addr;
    logic [IW-1:0] ar_id;
    logic          aw_valid, aw_ready, aw_lock;
    logic [AW-1:0] aw_addr;
    logic [IW-1:0] aw_id;
    logic [5:0]    aw_atop;
    logic          sc_stall, sc_valid, sc_ready, sc_success;
    logic [IW-1:0] sc_id;
    logic [$clog2(NR+1)-1:0] resv_count;

    int errors = 0;
    int checks = 0;
    logic [IW:0] exp_q [$];

    always #5 clk = ~clk;

    axi_riscv_resv_tracker #(
        .AXI_ADDR_WIDTH     (AW),
        .AXI_ID_WIDTH       (IW),
        .NUM_RESV           (NR),
        .RESV_GRANULE_BYTES (8),
        .RESULT_DEPTH       (4),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .ar_valid_i   (ar_valid),
        .ar_ready_i   (ar_ready),
        .ar_addr_i    (ar_addr),
        .ar_id_i      (ar_id),
        .ar_lock_i    (ar_lock),
        .aw_valid_i   (aw_valid),
        .aw_ready_i   (aw_ready),
        .aw_addr_i    (aw_addr),
        .aw_id_i      (aw_id),
        .aw_lock_i    (aw_lock),
        .aw_atop_i    (aw_atop),
        .sc_stall_o   (sc_stall),
        .sc_valid_o   (sc_valid),
        .sc_ready_i   (sc_ready),
        .sc_id_o      (sc_id),
        .sc_success_o (sc_success),
        .resv_count_o (resv_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs take effect at the rising edge, outputs are sampled at the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lr(input logic [IW-1:0] id, input logic [AW-1:0] addr);
        ar_valid = 1'b1; ar_ready = 1'b1; ar_lock = 1'b1; ar_id = id; ar_addr = addr;
        cyc();
        ar_valid = 1'b0; ar_lock = 1'b0;
        $display("LR    id=%0d addr=%h count=%0d", id, addr, resv_count);
    endtask

    task automatic aw(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                      input logic lock, input logic [5:0] atop);
        aw_valid = 1'b1; aw_ready = 1'b1; aw_lock = lock; aw_atop = atop;
        aw_id = id; aw_addr = addr;
        cyc();
        aw_valid = 1'b0; aw_lock = 1'b0; aw_atop = 6'd0;
        $display("AW    id=%0d addr=%h lock=%0d atop=%h count=%0d", id, addr, lock, atop, resv_count);
    endtask

    task automatic sc(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic ok);
        exp_q.push_back({id, ok});
        aw(id, addr, 1'b1, 6'd0);
    endtask

    // Compares the FIFO head with the oldest queued expectation, then pops it.
    task automatic check_verdict(input string tag);
        logic [IW:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk({tag, ".valid"}, 64'(sc_valid), 64'(1));
        chk({tag, ".id"}, 64'(sc_id), 64'(e[IW:1]));
        chk({tag, ".success"}, 64'(sc_success), 64'(e[0]));
        $display("SC    %s id=%0d success=%0d (expected id=%0d success=%0d)",
                 tag, sc_id, sc_success, e[IW:1], e[0]);
        sc_ready = 1'b1;
        cyc();
        sc_ready = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        ar_valid = 1'b0; ar_ready = 1'b0; ar_lock = 1'b0; ar_addr = '0; ar_id = '0;
        aw_valid = 1'b0; aw_ready = 1'b0; aw_lock = 1'b0; aw_addr = '0; aw_id = '0;
        aw_atop = 6'd0; sc_ready = 1'b0;
        cyc();
        cyc();
        chk("rst.sc_valid", 64'(sc_valid), 64'(0));
        chk("rst.sc_stall", 64'(sc_stall), 64'(0));
        chk("rst.count", 64'(resv_count), 64'(0));
        chk("rst.sc_id", 64'(sc_id), 64'(0));
        chk("rst.sc_success", 64'(sc_success), 64'(0));
        rst_ni = 1'b1;
        cyc();

        // LR then SC in the same granule succeeds and frees the entry
        lr(4'd3, 32'h1000);
        chk("basic.count_after_lr", 64'(resv_count), 64'(1));
        sc(4'd3, 32'h1004, 1'b1);
        chk("basic.count_after_sc", 64'(resv_count), 64'(0));
        check_verdict("basic");

        // Plain write from another ID kills the reservation
        lr(4'd1, 32'h2000);
        aw(4'd5, 32'h2000, 1'b0, 6'd0);
        chk("write.count", 64'(resv_count), 64'(0));
        sc(4'd1, 32'h2000, 1'b0);
        check_verdict("write");

        // Locked ATOP counts as a plain write and yields no verdict
        lr(4'd6, 32'h3000);
        aw(4'd6, 32'h3000, 1'b1, 6'h20);
        chk("atop.no_verdict", 64'(sc_valid), 64'(0));
        sc(4'd6, 32'h3000, 1'b0);
        check_verdict("atop");

        // Unlocked AR leaves the table alone
        ar_valid = 1'b1; ar_ready = 1'b1; ar_lock = 1'b0; ar_id = 4'd7; ar_addr = 32'h5000;
        cyc();
        ar_valid = 1'b0;
        sc(4'd7, 32'h5000, 1'b0);
        check_verdict("plain_ar");

        // Table overflow evicts the entry at the victim pointer (entry 0, id 0)
        for (int i = 0; i < 5; i++) begin
            lr(4'(i), 32'((i + 1) * 32'h100));
        end
        chk("evict.count", 64'(resv_count), 64'(4));
        sc(4'd0, 32'h100, 1'b0);
        check_verdict("evict.id0");
        sc(4'd4, 32'h500, 1'b1);
        check_verdict("evict.id4");
        chk("evict.count_after", 64'(resv_count), 64'(3));

        // Successful SC clears other IDs holding the same granule
        lr(4'd8, 32'h6000);
        lr(4'd9, 32'h6004);
        sc(4'd8, 32'h6000, 1'b1);
        chk("granule.count", 64'(resv_count), 64'(2));
        check_verdict("granule.id8");
        sc(4'd9, 32'h6004, 1'b0);
        check_verdict("granule.id9");

        // Verdict FIFO fills while sc_ready is low, then drains in order
        lr(4'd12, 32'h7000);
        sc(4'd10, 32'h7000, 1'b0);
        sc(4'd11, 32'h7000, 1'b0);
        sc(4'd12, 32'h7000, 1'b1);
        sc(4'd13, 32'h7000, 1'b0);
        chk("fifo.stall_full", 64'(sc_stall), 64'(1));
        check_verdict("fifo.0");
        chk("fifo.stall_after_pop", 64'(sc_stall), 64'(0));
        check_verdict("fifo.1");
        check_verdict("fifo.2");
        check_verdict("fifo.3");
        chk("fifo.empty", 64'(sc_valid), 64'(0));

        // Same-cycle LR and write to one granule: old holder cleared, new LR survives
        lr(4'd5, 32'h40);
        ar_valid = 1'b1; ar_ready = 1'b1; ar_lock = 1'b1; ar_id = 4'd2; ar_addr = 32'h40;
        aw_valid = 1'b1; aw_ready = 1'b1; aw_lock = 1'b0; aw_id = 4'd7; aw_addr = 32'h40;
        cyc();
        ar_valid = 1'b0; ar_lock = 1'b0; aw_valid = 1'b0;
        $display("LR+AW id=2 addr=00000040 count=%0d", resv_count);
        sc(4'd5, 32'h40, 1'b0);
        check_verdict("same_cycle.id5");
        sc(4'd2, 32'h40, 1'b1);
        check_verdict("same_cycle.id2");

        // Long wait between LR and SC
        lr(4'd14, 32'h8000);
        repeat (20) cyc();
`ifdef AXI_RISCV_RESV_TIMEOUT_EN
        sc(4'd14, 32'h8000, 1'b0);
`else
        sc(4'd14, 32'h8000, 1'b1);
`endif
        check_verdict("timeout");

        // Reset mid-operation drops the pending verdict, the table, and the in-reset LR
        lr(4'd1, 32'h9000);
        aw_valid = 1'b1; aw_ready = 1'b1; aw_lock = 1'b1; aw_id = 4'd1; aw_addr = 32'h9000;
        cyc();
        aw_valid = 1'b0; aw_lock = 1'b0;
        rst_ni = 1'b0;
        ar_valid = 1'b1; ar_ready = 1'b1; ar_lock = 1'b1; ar_id = 4'd2; ar_addr = 32'hA000;
        cyc();
        ar_valid = 1'b0; ar_lock = 1'b0;
        rst_ni = 1'b1;
        exp_q.delete();
        chk("reset_op.sc_valid", 64'(sc_valid), 64'(0));
        chk("reset_op.count", 64'(resv_count), 64'(0));
        $display("RESET count=%0d sc_valid=%0d", resv_count, sc_valid);
        sc(4'd1, 32'h9000, 1'b0);
        check_verdict("reset_op");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
